// File: rtl/stage_pkg.sv
// Shared pipeline types for the register-read stage: instruction bundle,
// register index and the operand bundle handed to execute.
package stage;
    localparam int ADDR_WIDTH = 30;
    localparam int XLEN       = 32;
    localparam int NREGS      = 32;

    typedef logic [4:0] RegIdx;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           insn;
    } InsnBundle;

    typedef struct packed {
        InsnBundle       insn;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        RegIdx           rd;
        logic            rd_we;
    } OpBundle;

    function automatic RegIdx rs1_of(input logic [31:0] insn);
        return insn[19:15];
    endfunction

    function automatic RegIdx rs2_of(input logic [31:0] insn);
        return insn[24:20];
    endfunction

    function automatic RegIdx rd_of(input logic [31:0] insn);
        return insn[11:7];
    endfunction
endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// One busy bit per GPR. pending already hides a register whose writeback
// lands this cycle, so readers can be released in the same cycle.
module reg_scoreboard
    import stage::*;
#(
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  RegIdx            set_idx,
    input  logic             clr_en,
    input  RegIdx            clr_idx,
    input  logic             clear_all,
    output logic [NREGS-1:0] pending
);
    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    // Clear before set so a new writer issued in the writeback cycle stays busy.
    always_comb begin
        sb_d = sb_q;
        if (clear_all) begin
            sb_d = '0;
        end else begin
            if (clr_en) sb_d[clr_idx] = 1'b0;
            if (set_en) sb_d[set_idx] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < NREGS; r++) begin
            pending[r] = sb_q[r] & ~(clr_en && (clr_idx == RegIdx'(r)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: reads rs1/rs2 with writeback bypass, stalls on
// scoreboard hazards and hands operands to execute through a register slice.
module operand_fetch
    import stage::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int ADDR_WIDTH = stage::ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  InsnBundle        in_insn,
    input  logic             in_rd_we,
    output logic             out_valid,
    input  logic             out_ready,
    output InsnBundle        out_insn,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output RegIdx            out_rd,
    output logic             out_rd_we,
    input  logic             wb_valid,
    input  RegIdx            wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush
);
    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and an offered output is held
    // unchanged until it is taken.

    if (ADDR_WIDTH != stage::ADDR_WIDTH || XLEN != stage::XLEN) begin : g_param_check
        $error("operand_fetch: XLEN/ADDR_WIDTH must match package stage");
    end

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    OpBundle          out_q;
    OpBundle          out_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic [NREGS-1:0] pending;
    RegIdx            rs1;
    RegIdx            rs2;
    RegIdx            rd;
    logic             hazard;
    logic             accept;
    logic             set_en;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;

    assign rs1 = rs1_of(in_insn.insn);
    assign rs2 = rs2_of(in_insn.insn);
    assign rd  = rd_of(in_insn.insn);

    assign hazard   = pending[rs1] | pending[rs2] | (in_rd_we & pending[rd]);
    assign in_ready = ~rst & ~flush & ~hazard & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign set_en   = accept & in_rd_we & (rd != '0);

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_idx   (rd),
        .clr_en    (wb_valid),
        .clr_idx   (wb_rd),
        .clear_all (flush),
        .pending   (pending)
    );

    // Operand mux: x0 reads zero, a same-cycle writeback beats the regfile.
    always_comb begin
        rs1_val = regs_q[rs1];
        if (rs1 == '0) begin
            rs1_val = '0;
        end else if (wb_valid && wb_rd == rs1) begin
            rs1_val = wb_data;
        end
        rs2_val = regs_q[rs2];
        if (rs2 == '0) begin
            rs2_val = '0;
        end else if (wb_valid && wb_rd == rs2) begin
            rs2_val = wb_data;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_valid && wb_rd != '0) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_d.insn    = in_insn;
            out_d.rs1_val = rs1_val;
            out_d.rs2_val = rs2_val;
            out_d.rd      = rd;
            out_d.rd_we   = in_rd_we & (rd != '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            regs_q      <= regs_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_insn    = out_q.insn;
    assign out_rs1_val = out_q.rs1_val;
    assign out_rs2_val = out_q.rs2_val;
    assign out_rd      = out_q.rd;
    assign out_rd_we   = out_q.rd_we;
endmodule
